// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: one sequential shift-add signed multiplier (one multiplier
// bit per cycle) shared by two requesters through a round-robin arbiter.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req0_valid/a/b/ready     requester 0 valid/ready operand channel
//   req1_valid/a/b/ready     requester 1 valid/ready operand channel
//   rsp_valid/id/p/ready     tagged product channel (id = owning requester)
//   busy                     high whenever the unit is not idle
module mul_share_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 req1_ready,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_p,
    input  logic                 rsp_ready,
    output logic                 busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] ma;
    logic [WIDTH-1:0] mb;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    cnt;
    logic             sign;
    logic             id;
    logic             last;

    logic             gnt_valid;
    logic             gnt_id;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [PW-1:0]    partial;
    logic [PW-1:0]    acc_step;
    logic [PW-1:0]    acc_neg;

    // Unsigned magnitude; the most-negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? WIDTH'(~x + 1'b1) : x;
    endfunction

    // Round-robin arbitration, only while idle; contention goes to !last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = ~last;
            end else if (req0_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b0;
            end else if (req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
        end
    end

    assign req0_ready = gnt_valid && !gnt_id;
    assign req1_ready = gnt_valid && gnt_id;
    assign busy       = (state != IDLE);

    assign sel_a = gnt_id ? req1_a : req0_a;
    assign sel_b = gnt_id ? req1_b : req0_b;

    // One shift-add step and the signed result built from its outcome.
    assign partial  = PW'(ma) << cnt;
    assign acc_step = mb[0] ? PW'(acc + partial) : acc;
    assign acc_neg  = PW'(~acc_step + 1'b1);

    // Control FSM with registered datapath and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ma        <= '0;
            mb        <= '0;
            acc       <= '0;
            cnt       <= '0;
            sign      <= 1'b0;
            id        <= 1'b0;
            last      <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_p     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        ma    <= mag(sel_a);
                        mb    <= mag(sel_b);
                        sign  <= sel_a[WIDTH-1] ^ sel_b[WIDTH-1];
                        id    <= gnt_id;
                        last  <= gnt_id;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    mb  <= mb >> 1;
                    cnt <= CW'(cnt + 1'b1);
                    // Last multiplier bit (MSB of the magnitude) processed here.
                    if (cnt == CW'(WIDTH - 1)) begin
                        rsp_p     <= sign ? acc_neg : acc_step;
                        rsp_id    <= id;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Scoreboard bench for mul_share_ctrl: accepted requests push the expected
// tagged product (plain signed multiply) into a queue; a monitor pops and
// compares each response, and checks arbitration, hold and latency.
module tb_mul_share_ctrl;

    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req0_valid = 1'b0;
    logic [W-1:0]   req0_a = '0;
    logic [W-1:0]   req0_b = '0;
    logic           req0_ready;
    logic           req1_valid = 1'b0;
    logic [W-1:0]   req1_a = '0;
    logic [W-1:0]   req1_b = '0;
    logic           req1_ready;
    logic           rsp_valid;
    logic           rsp_id;
    logic [2*W-1:0] rsp_p;
    logic           rsp_ready = 1'b0;
    logic           busy;

    mul_share_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_p      (rsp_p),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           id;
        logic [2*W-1:0] p;
        int             edge_no;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   idle_m   = 1'b1;
    bit   last_m   = 1'b1;
    bit   holding  = 1'b0;
    logic           hid;
    logic [2*W-1:0] hp;
    int   rr_mode  = 0;
    bit   rr_hold  = 1'b0;

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        int ia;
        int ib;
        ia = $signed(a);
        ib = $signed(b);
        return (2*W)'(ia * ib);
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 8'h80;
            1:       return 8'h7F;
            2:       return 8'h00;
            3:       return 8'hFF;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Response consumer: always-ready, random, or held by the main sequence.
    always @(posedge clk) begin
        #1;
        if (rr_mode == 0)      rsp_ready = 1'b1;
        else if (rr_mode == 1) rsp_ready = 1'($urandom_range(0, 1));
        else                   rsp_ready = rr_hold;
    end

    // Monitor: arbitration model, scoreboard push on accept, pop on response.
    always @(negedge clk) begin : mon
        logic g_v;
        logic g_id;
        exp_t e;
        if (rst) begin
            sbq.delete();
            idle_m  = 1'b1;
            last_m  = 1'b1;
            holding = 1'b0;
        end else begin
            g_v  = 1'b0;
            g_id = 1'b0;
            if (idle_m) begin
                if (req0_valid && req1_valid) begin g_v = 1'b1; g_id = !last_m; end
                else if (req0_valid)          begin g_v = 1'b1; g_id = 1'b0;    end
                else if (req1_valid)          begin g_v = 1'b1; g_id = 1'b1;    end
            end
            chk("req0_ready", 32'(req0_ready), 32'(g_v && !g_id));
            chk("req1_ready", 32'(req1_ready), 32'(g_v && g_id));
            chk("busy", 32'(busy), 32'(!idle_m));

            if (req0_valid && req0_ready) begin
                sbq.push_back('{id: 1'b0, p: ref_prod(req0_a, req0_b), edge_no: cyc + 1});
                last_m = 1'b0;
                idle_m = 1'b0;
            end
            if (req1_valid && req1_ready) begin
                sbq.push_back('{id: 1'b1, p: ref_prod(req1_a, req1_b), edge_no: cyc + 1});
                last_m = 1'b1;
                idle_m = 1'b0;
            end

            if (holding) begin
                chk("hold_valid", 32'(rsp_valid), 32'd1);
                chk("hold_id", 32'(rsp_id), 32'(hid));
                chk("hold_p", 32'(rsp_p), 32'(hp));
            end else if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_rsp: got id %0d p 0x%0h, want no response", rsp_id, rsp_p);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_p", 32'(rsp_p), 32'(e.p));
                    chk("latency", 32'(cyc - e.edge_no), 32'(W));
                end
            end
            hid     = rsp_id;
            hp      = rsp_p;
            holding = rsp_valid && !rsp_ready;
            if (rsp_valid && rsp_ready) idle_m = 1'b1;
        end
    end

    task automatic send(input bit n, input logic [W-1:0] a, input logic [W-1:0] b);
        int guard;
        bit done;
        @(posedge clk);
        #1;
        if (n == 1'b0) begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
        else           begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
        guard = 0;
        done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            if ((n == 1'b0 && req0_ready) || (n == 1'b1 && req1_ready)) done = 1'b1;
            else begin
                guard++;
                if (guard > 3000) begin
                    n_checks++;
                    $display("FAIL accept_timeout: requester %0d got no ready in 3000 cycles, want ready", n);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        // Operands are scrambled once accepted; they must no longer matter.
        if (n == 1'b0) begin req0_valid = 1'b0; req0_a = W'($urandom); req0_b = W'($urandom); end
        else           begin req1_valid = 1'b0; req1_a = W'($urandom); req1_b = W'($urandom); end
    endtask

    task automatic wait_rsp();
        int guard;
        guard = 0;
        while (!rsp_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!rsp_valid) begin
            n_checks++;
            $display("FAIL rsp_timeout: got rsp_valid 0 after 200 cycles, want 1");
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sbq.size() != 0 || !idle_m) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (sbq.size() != 0 || !idle_m) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d outstanding after 3000 cycles, want 0", sbq.size());
        end
    endtask

    initial begin
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_p", 32'(rsp_p), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        rr_mode = 0;
        // Basic, extremes and sign/zero cases.
        send(1'b0, 8'd3, 8'd5);
        send(1'b1, 8'h80, 8'h80);
        send(1'b1, 8'h7F, 8'h80);
        send(1'b0, 8'hFF, 8'h00);
        send(1'b0, 8'hFF, 8'hFF);
        send(1'b1, 8'hF9, 8'd6);
        send(1'b0, 8'h80, 8'd1);
        drain();

        // Contention: both held high, grants must alternate.
        fork
            begin repeat (2) send(1'b0, rnd_op(), rnd_op()); end
            begin repeat (2) send(1'b1, rnd_op(), rnd_op()); end
        join
        drain();

        // Back-pressure in DONE with a request pending from the other side.
        rr_mode = 2;
        rr_hold = 1'b0;
        fork
            send(1'b0, 8'd9, 8'hF3);
            begin repeat (2) @(posedge clk); send(1'b1, 8'd100, 8'd100); end
            begin wait_rsp(); repeat (5) @(negedge clk); rr_hold = 1'b1; end
        join
        rr_mode = 0;
        drain();

        // Reset three cycles into a requester-1 operation.
        send(1'b1, 8'd5, 8'd7);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrun_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrun_busy", 32'(busy), 32'd0);
        chk("midrun_rsp_p", 32'(rsp_p), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        fork
            send(1'b0, 8'd11, 8'hFD);
            send(1'b1, 8'hC0, 8'd2);
        join
        drain();

        // Randomized traffic with random consumer back-pressure.
        rr_mode = 1;
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    send(1'b0, rnd_op(), rnd_op());
                end
            end
            begin
                for (int j = 0; j < 25; j++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    send(1'b1, rnd_op(), rnd_op());
                end
            end
        join
        rr_mode = 0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
